// File: rtl/bin2bcd_digit_streamer_if.sv
// Handshake bundle between the binary-to-BCD digit streamer and its
// neighbours: the request side (Start/Bin_in/Busy/Overflow) and the
// per-digit stream side (Digit_out/Digit_valid/Digit_ready/Digit_idx/Last).
// The slave modport is the streamer itself; the master modport is whatever
// issues requests and consumes digits.
interface bin2bcd_digit_streamer_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic             Start;
    logic [BIN_W-1:0] Bin_in;
    logic             Busy;
    logic [3:0]       Digit_out;
    logic             Digit_valid;
    logic             Digit_ready;
    logic [IDX_W-1:0] Digit_idx;
    logic             Last;
    logic             Overflow;

    modport master (
        output Start, Bin_in, Digit_ready,
        input  Busy, Digit_out, Digit_valid, Digit_idx, Last, Overflow
    );

    modport slave (
        input  Start, Bin_in, Digit_ready,
        output Busy, Digit_out, Digit_valid, Digit_idx, Last, Overflow
    );
endinterface

// File: rtl/bin2bcd_digit_streamer.sv
// Binary-to-BCD digit streamer for the frequency meter display path.
// A captured binary value is converted with a sequential shift-add-3
// (double-dabble) engine, one bit per cycle, then the BCD digits are
// streamed most-significant first over a valid/ready handshake.
// Values above 10^DIGITS-1 raise Overflow and stream as all nines, so the
// downstream ASCII converter only ever sees decimal codes.
//
// Optional build macro: BCD_LZ_SUPPRESS_EN
//   defined   - the stream starts at the highest non-zero digit (value 0
//               emits a single 0 at index 0); overflow still emits all nines.
//   undefined - all DIGITS digits are emitted, leading zeros included.
module bin2bcd_digit_streamer #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input logic                     CLK,
    input logic                     RST_N,
    bin2bcd_digit_streamer_if.slave bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(DIGITS - 1);

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value(DIGITS);

    // Pick one BCD nibble out of the packed digit field.
    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] bcd,
                                            input logic [IDX_W-1:0] idx);
        return bcd[4*int'(idx) +: 4];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SEND
    } state_t;

    state_t           state;
    logic [SR_W-1:0]  sreg;        // {BCD digits, binary bits being shifted out}
    logic [SR_W-1:0]  sreg_step;
    logic [CNT_W-1:0] step_cnt;
    logic [BCD_W-1:0] bcd_send;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] next_idx;

    logic             busy_q;
    logic             valid_q;
    logic [3:0]       digit_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic             ovf_q;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        // NOTE: full default before the conditional updates, so no path leaves
        // sreg_step unassigned and no latch is inferred.
        sreg_step = sreg;
        for (int i = 0; i < DIGITS; i++) begin
            if (sreg[BIN_W + 4*i +: 4] >= 4'd5) begin
                sreg_step[BIN_W + 4*i +: 4] = sreg[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sreg_step = sreg_step << 1;
    end

    // Digits to stream: the converted value, or all nines on overflow.
    always_comb begin
        bcd_send = ovf_q ? {DIGITS{4'd9}} : sreg[SR_W-1:BIN_W];
    end

`ifdef BCD_LZ_SUPPRESS_EN
    // Start at the highest non-zero digit; an all-zero value starts at 0.
    always_comb begin
        first_idx = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_send[4*i +: 4] != 4'd0) begin
                first_idx = IDX_W'(i);
            end
        end
    end
`else
    // Every digit is sent, so the stream always starts at the top digit.
    assign first_idx = TOP_IDX;
`endif

    assign next_idx = idx_q - IDX_W'(1);

    // Control FSM: capture, BIN_W shift-add-3 steps, then the digit stream.
    // SEND spends its first cycle loading the first digit, so the first
    // valid digit appears BIN_W+1 edges after the accepted Start.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the shift register is an ordinary datapath register, not a
            // memory array, so it is cleared with the rest of the state.
            state    <= IDLE;
            sreg     <= '0;
            step_cnt <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            digit_q  <= 4'd0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge value of every other register.
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        sreg     <= {{BCD_W{1'b0}}, bus.Bin_in};
                        ovf_q    <= (64'(bus.Bin_in) > MAX_VAL);
                        step_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    sreg     <= sreg_step;
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (step_cnt == LAST_STEP) begin
                        state <= SEND;
                    end
                end

                SEND: begin
                    if (!valid_q) begin
                        // Entry cycle: commit saturation and present the first digit.
                        sreg[SR_W-1:BIN_W] <= bcd_send;
                        idx_q              <= first_idx;
                        digit_q            <= digit_at(bcd_send, first_idx);
                        last_q             <= (first_idx == '0);
                        valid_q            <= 1'b1;
                    end else if (bus.Digit_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            idx_q   <= next_idx;
                            digit_q <= digit_at(bcd_send, next_idx);
                            last_q  <= (next_idx == '0);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy        = busy_q;
    assign bus.Digit_out   = digit_q;
    assign bus.Digit_valid = valid_q;
    assign bus.Digit_idx   = idx_q;
    assign bus.Last        = last_q;
    assign bus.Overflow    = ovf_q;

endmodule

// File: tb/tb_bin2bcd_digit_streamer.sv
// Bench for bin2bcd_digit_streamer: directed conversions with hand-computed
// digit strings, an arithmetic decimal-digit model feeding an expected-digit
// queue, and one negedge compare process that checks every valid digit.
module tb_bin2bcd_digit_streamer;

    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_digit_streamer_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus();

    bin2bcd_digit_streamer #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] digit;
        int         idx;
        bit         last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          ready_mode = 0;   // 0: always ready, 1: ready every 3rd cycle, 2: never
    logic [31:0] got_packed;
    int          got_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint unsigned pow10(input int k);
        longint unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    // Expected stream from plain decimal arithmetic.
    task automatic model_push(input longint unsigned v, output bit ovf, output int n);
        int top;
        logic [3:0] d[DIGITS];
        ovf = (v > pow10(DIGITS) - 1);
        for (int k = 0; k < DIGITS; k++)
            d[k] = ovf ? 4'd9 : 4'((v / pow10(k)) % 10);
        top = DIGITS - 1;
`ifdef BCD_LZ_SUPPRESS_EN
        if (!ovf) begin
            top = 0;
            for (int k = 0; k < DIGITS; k++) if (d[k] != 0) top = k;
        end
`endif
        n = top + 1;
        for (int k = top; k >= 0; k--) exp_q.push_back('{digit: d[k], idx: k, last: (k == 0)});
    endtask

    // Ready driver: changes just after each rising edge.
    initial begin
        int rcyc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.Digit_ready = 1'b1;
                1:       bus.Digit_ready = (rcyc % 3 == 0);
                default: bus.Digit_ready = 1'b0;
            endcase
            rcyc++;
        end
    end

    // Compare process: every valid digit against the head of the model queue.
    always @(negedge clk) begin
        if (rst_n && bus.Digit_valid) begin
            check("busy_while_valid", bus.Busy, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_digit", bus.Digit_out, 64'hFFFF);
            end else begin
                check("digit_out", bus.Digit_out, exp_q[0].digit);
                check("digit_idx", bus.Digit_idx, exp_q[0].idx);
                check("last",      bus.Last,      exp_q[0].last);
                if (bus.Digit_ready) begin
                    got_packed = {got_packed[27:0], bus.Digit_out};
                    got_n++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  bus.Busy,        0);
        check({tag, "_valid"}, bus.Digit_valid, 0);
        check({tag, "_digit"}, bus.Digit_out,   0);
        check({tag, "_idx"},   bus.Digit_idx,   0);
        check({tag, "_last"},  bus.Last,        0);
        check({tag, "_ovf"},   bus.Overflow,    0);
    endtask

    // One full conversion with literal expectations for digits, count and overflow.
    task automatic convert(input longint unsigned v, input int mode, input int inject,
                           input bit hold_start, input logic [31:0] lit,
                           input int lit_n, input bit lit_ovf);
        bit          m_ovf;
        int          m_n;
        logic [31:0] mp;
        int          lat;
        int          s;
        bit          seen;
        logic [63:0] vv;
        ready_mode = mode;
        model_push(v, m_ovf, m_n);
        mp = 0;
        foreach (exp_q[i]) mp = {mp[27:0], exp_q[i].digit};
        check("model_digits", mp, lit);
        check("model_count", m_n, lit_n);
        check("model_ovf", m_ovf, lit_ovf);
        got_packed = 0;
        got_n = 0;
        vv = v;
        @(posedge clk); #1;
        bus.Start  = 1'b1;
        bus.Bin_in = vv[BIN_W-1:0];
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("busy_after_start", bus.Busy, 1);
        lat = 0;
        seen = 0;
        while (!seen && lat < 100) begin
            if (lat == inject) begin
                bus.Start  = 1'b1;
                bus.Bin_in = 27'd1;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            seen = bus.Digit_valid;
        end
        bus.Start = 1'b0;
        check("first_valid_latency", lat, 28);
        s = 0;
        if (hold_start) begin
            bus.Start  = 1'b1;
            bus.Bin_in = 27'd5;
        end
        while (bus.Busy && s < 500) begin
            @(posedge clk); #1;
            s++;
        end
        bus.Start = 1'b0;
        check("busy_released", bus.Busy, 0);
        if (mode == 0) check("stream_cycles", s, lit_n);
        check("queue_drained", exp_q.size(), 0);
        check("overflow", bus.Overflow, lit_ovf);
        check("digits", got_packed, lit);
        check("digit_count", got_n, lit_n);
        if (hold_start) begin
            @(posedge clk); #1;
            check("start_at_last_ignored", bus.Busy, 0);
        end
    endtask

    initial begin
        bus.Start       = 1'b0;
        bus.Bin_in      = '0;
        bus.Digit_ready = 1'b1;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        convert(12345678, 0, -1, 0, 32'h12345678, 8, 0);
`ifdef BCD_LZ_SUPPRESS_EN
        convert(0,     0, -1, 0, 32'h00000000, 1, 0);
        convert(907,   0, -1, 0, 32'h00000907, 3, 0);
        convert(40506, 1, -1, 0, 32'h00040506, 5, 0);
`else
        convert(0,     0, -1, 0, 32'h00000000, 8, 0);
        convert(907,   0, -1, 0, 32'h00000907, 8, 0);
        convert(40506, 1, -1, 0, 32'h00040506, 8, 0);
`endif
        convert(100000000, 0, -1, 0, 32'h99999999, 8, 1);
        convert(99999999,  0, -1, 1, 32'h99999999, 8, 0);
        convert(12345678,  0,  5, 0, 32'h12345678, 8, 0);

        // Reset in the middle of SHIFT.
        ready_mode = 0;
        @(posedge clk); #1;
        bus.Start  = 1'b1;
        bus.Bin_in = 27'd100000000;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("ovf_before_shift_reset", bus.Overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_shift");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("idle_after_shift_reset", bus.Digit_valid | bus.Busy, 0);

        // Reset in the middle of SEND while the consumer stalls.
        ready_mode = 2;
        begin
            bit o;
            int n;
            model_push(99999999, o, n);
        end
        @(posedge clk); #1;
        bus.Start  = 1'b1;
        bus.Bin_in = 27'd99999999;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        check("stalled_valid", bus.Digit_valid, 1);
        check("stalled_digit", bus.Digit_out, 9);
        check("stalled_idx", bus.Digit_idx, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_send");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_send_reset", bus.Digit_valid | bus.Busy, 0);

        convert(12345678, 0, -1, 0, 32'h12345678, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_digit_streamer.md
Name: bin2bcd_digit_streamer

Overview:
Upstream feeder for the per-digit ASCII converter in the equal-precision frequency meter. It captures a binary measurement result and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then streams the BCD digits MSB-first, one 4-bit digit per handshake, to the ASCII converter and display/UART path. Only the values 0–9 are ever emitted on Digit_out, because the downstream converter holds its output on non-decimal codes.

Parameters:
BIN_W, 27, width of the binary input. The default covers 0..99,999,999 plus overflow detection.
DIGITS, 8, number of BCD digits produced. IDX_W = clog2(DIGITS), minimum 1.

Ports:
CLK  input  1  system clock, rising-edge.
RST_N  input  1  asynchronous, active-low reset.
Start  input  1  single-cycle request to convert Bin_in; sampled only in IDLE.
Bin_in  input  BIN_W  binary value to convert; captured on the accepted Start.
Busy  output  1  high from the cycle after an accepted Start until the last digit handshake completes.
Digit_out  output  4  current BCD digit, 0..9.
Digit_valid  output  1  Digit_out/Digit_idx/Last are valid.
Digit_ready  input  1  downstream accepts the digit when Digit_valid && Digit_ready.
Digit_idx  output  IDX_W  position of the current digit; DIGITS-1 = most significant, 0 = least significant.
Last  output  1  current digit is the final one of this conversion.
Overflow  output  1  the captured Bin_in exceeded 10^DIGITS-1; held until the next accepted Start.

Behaviour:
- Reset (RST_N low, asynchronous): state = IDLE; Busy, Digit_out, Digit_valid, Digit_idx, Last, Overflow all 0; internal shift register and counters 0.
- Reset mid-operation aborts immediately. No partial stream resumes after release.
- FSM states: IDLE, SHIFT, SEND.
- IDLE:
  - Start=1 loads Bin_in into the low BIN_W bits of a (4*DIGITS+BIN_W)-bit shift register and clears the BCD bits.
  - On the same edge: Overflow <= (Bin_in > 10^DIGITS-1), shift counter <= 0, Busy <= 1, go to SHIFT.
- SHIFT, one step per cycle for exactly BIN_W cycles:
  - For each BCD nibble, if the nibble is ≥5, add 3.
  - Then shift the whole register left by 1.
  - After step BIN_W-1, go to SEND with the digit pointer = DIGITS-1.
- Overflow saturation: on entry to SEND, if Overflow=1, all digits are forced to 9.
- SEND:
  - Digit_valid=1; Digit_out = nibble[pointer]; Digit_idx = pointer; Last = (pointer == final index).
  - On valid && ready with Last=0, the pointer decrements.
  - On valid && ready with Last=1: Digit_valid <= 0, Busy <= 0, go to IDLE.
  - While valid && !ready, Digit_out, Digit_idx and Last hold stable.
- Latency: an accepted Start at edge 0 gives Busy=1 after edge 0 and first Digit_valid=1 after edge BIN_W+1 (28 with defaults). With Digit_ready tied high, the stream occupies DIGITS consecutive cycles.
- Start while Busy is ignored; Bin_in is not re-sampled.
- Start in the same cycle as the final handshake is ignored. Start is accepted only in IDLE.
- Bin_in = 0 produces all-zero digits. Bin_in = 10^DIGITS-1 produces all 9s with Overflow=0.

Optional Feature:
Macro BCD_LZ_SUPPRESS_EN.
- Defined:
  - On entry to SEND, the pointer starts at the highest non-zero digit, so leading zeros are not emitted and Digit_idx reflects true position.
  - Value 0 emits exactly one digit, 0, with Digit_idx=0 and Last=1.
  - Overflow saturation still emits all DIGITS nines.
- Undefined: all DIGITS digits are always emitted, including leading zeros.

Test Plan:
- Bin_in=12345678, Digit_ready=1 → first valid at edge 28; digits 1,2,3,4,5,6,7,8 with Digit_idx 7..0; Last only on 8; Overflow=0; Busy drops after the 8th handshake.
- Bin_in=0 → eight 0s (macro undefined). With BCD_LZ_SUPPRESS_EN: single 0, Digit_idx=0, Last=1. Bin_in=907 with the macro → 9,0,7 with Digit_idx 2,1,0.
- Bin_in=100000000 → Overflow=1; eight 9s. Bin_in=99999999 → Overflow=0; eight 9s.
- Bin_in=40506, Digit_ready toggled 1,0,0,1,... → each digit held stable while not ready; sequence 0,0,0,4,0,5,0,6 with no loss or duplication.
- Start pulsed again mid-SHIFT with Bin_in=1 → ignored; the original value is streamed. Start in IDLE afterwards is accepted.
- RST_N asserted mid-SHIFT and again mid-SEND → all outputs 0 asynchronously, FSM returns to IDLE. A new Start after release converts correctly.
